bin_to_gray_encoder: RTL and testbench

Registered binary-to-Gray encoder and Gray-code sequence generator, the transmit-side counterpart to the Gray-to-binary LED decoder. Accepts a binary value from the board switches, or steps an internal up/down count at a prescaled rate, and drives the corresponding Gray code to the decoder input or the LED bank. Every Gray output change between loads differs from the previous one in exactly one bit.

---
 rtl/bin_to_gray_encoder.sv | 117 +++++++++++
 tb/tb_bin_to_gray_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_gray_encoder.sv
// Registered binary-to-Gray encoder and prescaled up/down Gray sequence generator.
// Optional Gray transition checker enabled by defining GRAY_ERRCHK_EN.
module bin_to_gray_encoder #(
  parameter int WIDTH      = 4,
  parameter int DIV_CYCLES = 1
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             load_pi,
  input  logic [WIDTH-1:0] codigo_bin_pi,
  input  logic             en_pi,
  input  logic             up_pi,
  output logic [WIDTH-1:0] codigo_gray_po,
  output logic [WIDTH-1:0] codigo_bin_po,
  output logic             cambio_po,
  output logic             wrap_po,
  output logic             error_po
);

  localparam int PW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic [PW-1:0]    r_presc;
  logic             r_cambio;
  logic             r_wrap;

  logic             w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic [PW-1:0]    w_presc_nxt;

  assign w_step = en_pi & ~load_pi & (r_presc == PMAX);

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      load_pi: w_cnt_nxt = codigo_bin_pi;
      w_step: begin
        if (up_pi)
          w_cnt_nxt = r_cnt + WIDTH'(1);
        else
          w_cnt_nxt = r_cnt - WIDTH'(1);
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_wrap = 1'b0;
    if (w_step)
      w_wrap = up_pi ? (r_cnt == ONES) : (r_cnt == ZERO);
  end

  assign w_gray_nxt = w_cnt_nxt ^ (w_cnt_nxt >> 1);

  // Prescaler idles at 0 whenever disabled or reloaded.
  always_comb begin
    w_presc_nxt = '0;
    if (en_pi && !load_pi && (r_presc != PMAX))
      w_presc_nxt = r_presc + PW'(1);
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_cnt    <= '0;
      r_gray   <= '0;
      r_presc  <= '0;
      r_cambio <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_gray   <= w_gray_nxt;
      r_presc  <= w_presc_nxt;
      r_cambio <= load_pi | w_step;
      r_wrap   <= w_wrap;
    end
  end

  assign codigo_bin_po  = r_cnt;
  assign codigo_gray_po = r_gray;
  assign cambio_po      = r_cambio;
  assign wrap_po        = r_wrap;

`ifdef GRAY_ERRCHK_EN
  logic             r_chk_v;
  logic [WIDTH-1:0] r_chk_diff;
  logic             r_err;
  logic             w_one_hot;

  assign w_one_hot = (r_chk_diff != ZERO) &&
                     ((r_chk_diff & (r_chk_diff - WIDTH'(1))) == ZERO);

  // Diff captured on the step edge, judged on the following edge.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_chk_v    <= 1'b0;
      r_chk_diff <= '0;
      r_err      <= 1'b0;
    end else begin
      r_chk_v    <= w_step;
      r_chk_diff <= w_gray_nxt ^ r_gray;
      if (r_chk_v && !w_one_hot)
        r_err <= 1'b1;
    end
  end

  assign error_po = r_err;
`else
  assign error_po = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_gray_encoder.sv
// Scoreboard bench for bin_to_gray_encoder.
// Instance A uses DIV_CYCLES=3, instance B uses DIV_CYCLES=1.
module tb_bin_to_gray_encoder;

  typedef struct {
    int         cyc;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic [3:0] gt [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                          4'b0110, 4'b0111, 4'b0101, 4'b0100,
                          4'b1100, 4'b1101, 4'b1111, 4'b1110,
                          4'b1010, 4'b1011, 4'b1001, 4'b1000};

  logic       a_rst, a_load, a_en, a_up;
  logic [3:0] a_bin_i, a_gray, a_bin;
  logic       a_cam, a_wrap, a_err;
  logic       b_rst, b_load, b_en, b_up;
  logic [3:0] b_bin_i, b_gray, b_bin;
  logic       b_cam, b_wrap, b_err;

  bin_to_gray_encoder #(.WIDTH(4), .DIV_CYCLES(3)) u_a (
    .clk_pi(clk), .rst_pi(a_rst), .load_pi(a_load),
    .codigo_bin_pi(a_bin_i), .en_pi(a_en), .up_pi(a_up),
    .codigo_gray_po(a_gray), .codigo_bin_po(a_bin),
    .cambio_po(a_cam), .wrap_po(a_wrap), .error_po(a_err)
  );

  bin_to_gray_encoder #(.WIDTH(4), .DIV_CYCLES(1)) u_b (
    .clk_pi(clk), .rst_pi(b_rst), .load_pi(b_load),
    .codigo_bin_pi(b_bin_i), .en_pi(b_en), .up_pi(b_up),
    .codigo_gray_po(b_gray), .codigo_bin_po(b_bin),
    .cambio_po(b_cam), .wrap_po(b_wrap), .error_po(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_ev(input string p, input exp_t e,
                          input logic [3:0] b, input logic [3:0] g,
                          input logic w);
    chk({p, "_cycle"}, cyc, e.cyc);
    chk({p, "_bin"}, {28'd0, b}, {28'd0, e.bin});
    chk({p, "_gray"}, {28'd0, g}, {28'd0, e.gray});
    chk({p, "_wrap"}, {31'd0, w}, {31'd0, e.wrap});
    chk({p, "_gray_of_bin"}, {28'd0, g}, {28'd0, b ^ (b >> 1)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_cam === 1'b1) begin
      if (qa.size() == 0) begin
        chk("A_unexpected_cambio", 1, 0);
      end else begin
        e = qa.pop_front();
        check_ev("A", e, a_bin, a_gray, a_wrap);
      end
    end else begin
      chk("A_wrap_idle", {31'd0, a_wrap}, 0);
    end
    if (b_cam === 1'b1) begin
      if (qb.size() == 0) begin
        chk("B_unexpected_cambio", 1, 0);
      end else begin
        e = qb.pop_front();
        check_ev("B", e, b_bin, b_gray, b_wrap);
      end
    end else begin
      chk("B_wrap_idle", {31'd0, b_wrap}, 0);
    end
  end

  initial begin
    int n;
    {a_rst, a_load, a_en, a_up} = 4'b1100;
    {b_rst, b_load, b_en, b_up} = 4'b1100;
    a_bin_i = 4'hA;
    b_bin_i = 4'hA;
    tick(2);
    chk("A_rst_bin", {28'd0, a_bin}, 0);
    chk("A_rst_gray", {28'd0, a_gray}, 0);
    chk("A_rst_cambio", {31'd0, a_cam}, 0);
    chk("A_rst_err", {31'd0, a_err}, 0);
    chk("B_rst_bin", {28'd0, b_bin}, 0);
    chk("B_rst_gray", {28'd0, b_gray}, 0);
    {a_rst, a_load} = 2'b00;
    {b_rst, b_load} = 2'b00;
    tick();

    // Load 1011 -> Gray 1110
    n = cyc;
    a_load = 1'b1;
    a_bin_i = 4'b1011;
    qa.push_back('{n + 1, 4'hB, 4'b1110, 1'b0});
    tick();
    a_load = 1'b0;
    tick(2);

    // Up count with wrap, DIV=3
    n = cyc;
    a_load = 1'b1;
    a_bin_i = 4'hE;
    qa.push_back('{n + 1, 4'hE, 4'b1001, 1'b0});
    tick();
    a_load = 1'b0;
    a_en = 1'b1;
    a_up = 1'b1;
    qa.push_back('{n + 4, 4'hF, 4'b1000, 1'b0});
    qa.push_back('{n + 7, 4'h0, 4'b0000, 1'b1});
    tick(6);
    a_en = 1'b0;
    tick(2);

    // Load on the step cycle, then enable gating
    n = cyc;
    a_load = 1'b1;
    a_bin_i = 4'h0;
    qa.push_back('{n + 1, 4'h0, 4'b0000, 1'b0});
    tick();
    a_load = 1'b0;
    a_en = 1'b1;
    tick(2);
    a_load = 1'b1;
    a_bin_i = 4'h5;
    qa.push_back('{n + 4, 4'h5, 4'b0111, 1'b0});
    tick();
    a_load = 1'b0;
    qa.push_back('{n + 7, 4'h6, 4'b0101, 1'b0});
    tick(4);
    a_en = 1'b0;
    tick(2);
    a_en = 1'b1;
    qa.push_back('{n + 13, 4'h7, 4'b0100, 1'b0});
    tick(3);
    a_en = 1'b0;
    tick(2);

    // Reset mid-count with a colliding load
    a_en = 1'b1;
    tick();
    a_rst = 1'b1;
    a_load = 1'b1;
    a_bin_i = 4'h9;
    tick();
    chk("A_midrst_bin", {28'd0, a_bin}, 0);
    chk("A_midrst_gray", {28'd0, a_gray}, 0);
    chk("A_midrst_cambio", {31'd0, a_cam}, 0);
    {a_rst, a_load, a_en} = 3'b000;
    tick(4);

    // 32-step down/up sweep on B, DIV=1
    n = cyc;
    b_load = 1'b1;
    b_bin_i = 4'h0;
    qb.push_back('{n + 1, 4'h0, 4'b0000, 1'b0});
    tick();
    b_load = 1'b0;
    b_en = 1'b1;
    b_up = 1'b0;
    for (int k = 1; k <= 16; k++)
      qb.push_back('{n + 1 + k, 4'(16 - k), gt[16 - k], k == 1});
    tick(16);
    b_up = 1'b1;
    for (int j = 1; j <= 16; j++)
      qb.push_back('{n + 17 + j, 4'(j), gt[j % 16], j == 16});
    tick(16);
    b_en = 1'b0;
    tick(3);

    chk("A_error_po", {31'd0, a_err}, 0);
    chk("B_error_po", {31'd0, b_err}, 0);
    chk("A_queue_left", qa.size(), 0);
    chk("B_queue_left", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
